// File: rtl/buffer_stream_reader_pkg.sv
// buffer_stream_reader_pkg
//   Shared definitions for the buffer stream reader and the stream-fed
//   buffer writers: pixel geometry, reader FSM encoding and the buffer
//   address-width helper.
package buffer_stream_reader_pkg;

  localparam int unsigned PIXEL_WIDTH     = 16;
  localparam int unsigned SUB_PIXEL_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FINISH
  } reader_state_t;

  // Word address width of a 2^size byte buffer accessed stream_width bits at a time.
  function automatic int unsigned calc_addr_width(input int unsigned size,
                                                  input int unsigned stream_width);
    return size - $clog2(stream_width / 8);
  endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo
//   Two-entry fall-through FIFO between the RAM read port and the stream
//   output. When empty, the incoming word is presented on the output in the
//   same cycle and is only stored if the consumer does not take it.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     in_valid        incoming word valid (RAM data returned this cycle)
//     in_data         incoming word
//     out_ready       consumer ready
//     out_valid       head valid
//     out_data        head word (zero when nothing is valid)
//     count           number of stored entries (0..2)
module stream_skid_fifo #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             push;
  logic             pop;

  // Empty and consumer ready: the word passes straight through unstored.
  assign push      = in_valid && !(count == 2'd0 && out_ready);
  assign pop       = out_ready && (count != 2'd0);
  assign out_valid = (count != 2'd0) || in_valid;

  always_comb begin
    out_data = '0;
    if (count != 2'd0)
      out_data = mem[rd_ptr];
    else if (in_valid)
      out_data = in_data;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push)
        wr_ptr <= ~wr_ptr;
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/buffer_stream_reader.sv
// buffer_stream_reader
//   Reads beatCount words starting at startAddr from a 1-cycle-latency
//   buffer RAM and emits them as an AXI-Stream with tlast on the final beat.
//   Sustains one beat per cycle under full backpressure via a 2-entry skid
//   FIFO; address wraps modulo the buffer size.
//   Optional build macro: BUFFER_STREAM_READER_PIXEL_SWAP_EN reverses the
//   order of the 16-bit pixels within each output beat.
//   Ports:
//     clk, resetn            clock, asynchronous active-low reset
//     start                  transfer request (sampled in IDLE only)
//     startAddr, beatCount   first word address, number of beats (0 legal)
//     busy, done             transfer in progress, end-of-transfer pulse
//     memReadAddr/Cs/Data    RAM read port (data returned next cycle)
//     m_axis_*               AXI-Stream master
module buffer_stream_reader
  import buffer_stream_reader_pkg::*;
#(
  parameter  int unsigned STREAM_WIDTH = 16,
  parameter  int unsigned SIZE         = 14,
  localparam int unsigned ADDR_WIDTH   = calc_addr_width(SIZE, STREAM_WIDTH)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   startAddr,
  input  logic [ADDR_WIDTH:0]     beatCount,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   memReadAddr,
  output logic                    memReadCs,
  input  logic [STREAM_WIDTH-1:0] memReadData,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [STREAM_WIDTH-1:0] m_axis_tdata
);

  logic [1:0]              rst_sync;
  logic                    rst_n_i;
  reader_state_t           state;
  logic [ADDR_WIDTH:0]     beat_total;
  logic [ADDR_WIDTH:0]     issued_cnt;
  logic                    inflight;
  logic                    inflight_last;
  logic                    can_issue;
  logic                    rd_issue;
  logic [1:0]              fifo_count;
  logic [STREAM_WIDTH:0]   fifo_out;
  logic [STREAM_WIDTH-1:0] fifo_data;

  // Asynchronous assertion, synchronous release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      rst_sync <= 2'b00;
    else
      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_i = rst_sync[1];

  // Stored entries plus the outstanding read never exceed the FIFO depth.
  assign can_issue = (fifo_count == 2'd0) || (fifo_count == 2'd1 && !inflight);
  assign rd_issue  = (state == STREAM) && (issued_cnt < beat_total) && can_issue;
  assign memReadCs = rd_issue;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      memReadAddr   <= '0;
      beat_total    <= '0;
      issued_cnt    <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= rd_issue;
      if (rd_issue) begin
        memReadAddr   <= memReadAddr + ADDR_WIDTH'(1);
        issued_cnt    <= issued_cnt + (ADDR_WIDTH + 1)'(1);
        inflight_last <= (issued_cnt + (ADDR_WIDTH + 1)'(1) == beat_total);
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            memReadAddr <= startAddr;
            beat_total  <= beatCount;
            issued_cnt  <= '0;
            if (beatCount == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            state <= FINISH;
            done  <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  stream_skid_fifo #(
    .WIDTH (STREAM_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n_i),
    .in_valid  (inflight),
    .in_data   ({inflight_last, memReadData}),
    .out_ready (m_axis_tready),
    .out_valid (m_axis_tvalid),
    .out_data  (fifo_out),
    .count     (fifo_count)
  );

  assign m_axis_tlast = fifo_out[STREAM_WIDTH];
  assign fifo_data    = fifo_out[STREAM_WIDTH-1:0];

`ifdef BUFFER_STREAM_READER_PIXEL_SWAP_EN
  localparam int unsigned NUM_PIXELS = STREAM_WIDTH / PIXEL_WIDTH;

  always_comb begin
    m_axis_tdata = '0;
    for (int unsigned i = 0; i < NUM_PIXELS; i++)
      m_axis_tdata[i*PIXEL_WIDTH +: PIXEL_WIDTH] =
        fifo_data[(NUM_PIXELS-1-i)*PIXEL_WIDTH +: PIXEL_WIDTH];
  end
`else
  assign m_axis_tdata = fifo_data;
`endif

endmodule

// File: tb/tb_buffer_stream_reader.sv
// tb_buffer_stream_reader
//   Self-checking bench: 16-bit instance for the main transfer scenarios,
//   64-bit instance for the pixel-order option.
module tb_buffer_stream_reader;

  localparam int unsigned AW   = 13;
  localparam int unsigned AW64 = 11;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  logic          start         = 1'b0;
  logic [AW-1:0] startAddr     = '0;
  logic [AW:0]   beatCount     = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] memReadAddr;
  logic          memReadCs;
  logic [15:0]   memReadData   = '0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic [15:0]   m_axis_tdata;

  logic            start64     = 1'b0;
  logic [AW64-1:0] startAddr64 = '0;
  logic [AW64:0]   beatCount64 = '0;
  logic            busy64;
  logic            done64;
  logic [AW64-1:0] memReadAddr64;
  logic            memReadCs64;
  logic [63:0]     memReadData64 = '0;
  logic            tvalid64;
  logic            tready64    = 1'b0;
  logic            tlast64;
  logic [63:0]     tdata64;

  int n_checks = 0;
  int n_pass   = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  // RAM models: word content equals its address (16-bit), pattern + address (64-bit).
  always @(posedge clk) begin
    if (memReadCs)
      memReadData <= {3'b000, memReadAddr};
    if (memReadCs64)
      memReadData64 <= 64'h4444_3333_2222_1111 + {4{5'b00000, memReadAddr64}};
  end

  buffer_stream_reader #(
    .STREAM_WIDTH (16),
    .SIZE         (14)
  ) u_dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .startAddr     (startAddr),
    .beatCount     (beatCount),
    .busy          (busy),
    .done          (done),
    .memReadAddr   (memReadAddr),
    .memReadCs     (memReadCs),
    .memReadData   (memReadData),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdata  (m_axis_tdata)
  );

  buffer_stream_reader #(
    .STREAM_WIDTH (64),
    .SIZE         (14)
  ) u_dut64 (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start64),
    .startAddr     (startAddr64),
    .beatCount     (beatCount64),
    .busy          (busy64),
    .done          (done64),
    .memReadAddr   (memReadAddr64),
    .memReadCs     (memReadCs64),
    .memReadData   (memReadData64),
    .m_axis_tvalid (tvalid64),
    .m_axis_tready (tready64),
    .m_axis_tlast  (tlast64),
    .m_axis_tdata  (tdata64)
  );

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, memReadCs, m_axis_tvalid, m_axis_tlast} !== 5'b0)
      $display("FAIL reset_ctrl got=%b exp=%b", {busy, done, memReadCs, m_axis_tvalid, m_axis_tlast}, 5'b0);
    else n_pass++;
    n_checks++;
    if (memReadAddr !== '0) $display("FAIL reset_addr got=%h exp=0", memReadAddr);
    else n_pass++;
    n_checks++;
    if (m_axis_tdata !== '0) $display("FAIL reset_tdata got=%h exp=0", m_axis_tdata);
    else n_pass++;
    n_checks++;
    if ({busy64, done64, memReadCs64, tvalid64, tlast64} !== 5'b0 || tdata64 !== '0)
      $display("FAIL reset_dut64 got=%b/%h exp=0/0", {busy64, done64, memReadCs64, tvalid64, tlast64}, tdata64);
    else n_pass++;
    #1 resetn = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_basic();
    int unsigned beats = 0, dones = 0, first_v = 99, last_hs = 0;
    logic [16:0] e;
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 16'h0010 + 16'(i)});
    @(posedge clk); #1;
    start = 1'b1; startAddr = 13'h010; beatCount = 14'd4; m_axis_tready = 1'b1;
    for (int unsigned cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (m_axis_tvalid && first_v == 99) first_v = cyc;
      if (done) dones++;
      if (m_axis_tvalid && m_axis_tready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL basic_extra_beat got=%h exp=none", m_axis_tdata);
        else begin
          e = exp_q.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== e)
            $display("FAIL basic_beat got=%h exp=%h", {m_axis_tlast, m_axis_tdata}, e);
          else n_pass++;
        end
        beats++; last_hs = cyc;
      end
      @(posedge clk); #1; start = 1'b0;
    end
    n_checks++;
    if (first_v !== 2) $display("FAIL basic_latency got=%0d exp=2", first_v); else n_pass++;
    n_checks++;
    if (beats !== 4) $display("FAIL basic_beats got=%0d exp=4", beats); else n_pass++;
    n_checks++;
    if (last_hs !== first_v + 3) $display("FAIL basic_no_bubble got=%0d exp=%0d", last_hs, first_v + 3); else n_pass++;
    n_checks++;
    if (dones !== 1) $display("FAIL basic_done got=%0d exp=1", dones); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL basic_busy_end got=%b exp=0", busy); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [5:0] pat = 6'b101001;  // bit i = tready in cycle i mod 6: 1,0,0,1,0,1
    int unsigned beats = 0, reads = 0;
    logic held_v = 1'b0;
    logic [16:0] held = '0;
    logic [16:0] e;
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 16'h0010 + 16'(i)});
    @(posedge clk); #1;
    start = 1'b1; startAddr = 13'h010; beatCount = 14'd4; m_axis_tready = pat[0];
    for (int unsigned cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (held_v) begin
        n_checks++;
        if (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== held)
          $display("FAIL bp_stable got=%b/%h exp=1/%h", m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, held);
        else n_pass++;
      end
      n_checks++;
      if (reads + 32'(memReadCs) > beats + 2)
        $display("FAIL bp_read_ahead got=%0d exp<=2", reads + 32'(memReadCs) - beats);
      else n_pass++;
      if (memReadCs) reads++;
      if (m_axis_tvalid && m_axis_tready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL bp_extra_beat got=%h exp=none", m_axis_tdata);
        else begin
          e = exp_q.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== e)
            $display("FAIL bp_beat got=%h exp=%h", {m_axis_tlast, m_axis_tdata}, e);
          else n_pass++;
        end
        beats++;
      end
      held_v = m_axis_tvalid && !m_axis_tready;
      held   = {m_axis_tlast, m_axis_tdata};
      @(posedge clk); #1;
      start = 1'b0;
      m_axis_tready = pat[(cyc + 1) % 6];
    end
    n_checks++;
    if (beats !== 4) $display("FAIL bp_beats got=%0d exp=4", beats); else n_pass++;
    n_checks++;
    if (reads !== 4) $display("FAIL bp_reads got=%0d exp=4", reads); else n_pass++;
    m_axis_tready = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_wrap();
    logic [AW-1:0] addrs[$];
    logic [AW-1:0] exp_a [4] = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
    int unsigned beats = 0;
    logic [16:0] e;
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 3'b000, exp_a[i]});
    @(posedge clk); #1;
    start = 1'b1; startAddr = 13'h1FFE; beatCount = 14'd4; m_axis_tready = 1'b1;
    for (int unsigned cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (memReadCs) addrs.push_back(memReadAddr);
      if (m_axis_tvalid && m_axis_tready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL wrap_extra_beat got=%h exp=none", m_axis_tdata);
        else begin
          e = exp_q.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== e)
            $display("FAIL wrap_beat got=%h exp=%h", {m_axis_tlast, m_axis_tdata}, e);
          else n_pass++;
        end
        beats++;
      end
      @(posedge clk); #1; start = 1'b0;
    end
    n_checks++;
    if (addrs.size() !== 4) $display("FAIL wrap_read_count got=%0d exp=4", addrs.size()); else n_pass++;
    for (int i = 0; i < 4 && i < addrs.size(); i++) begin
      n_checks++;
      if (addrs[i] !== exp_a[i]) $display("FAIL wrap_addr got=%h exp=%h", addrs[i], exp_a[i]);
      else n_pass++;
    end
    n_checks++;
    if (beats !== 4) $display("FAIL wrap_beats got=%0d exp=4", beats); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_zero_and_ignore();
    logic saw_cs = 1'b0, saw_v = 1'b0;
    logic busy1 = 1'b0, done1 = 1'b0, busy2 = 1'b1;
    int unsigned dones = 0, beats = 0;
    logic [16:0] e;
    @(posedge clk); #1;
    start = 1'b1; startAddr = 13'h123; beatCount = 14'd0; m_axis_tready = 1'b1;
    for (int unsigned cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (memReadCs) saw_cs = 1'b1;
      if (m_axis_tvalid) saw_v = 1'b1;
      if (done) dones++;
      if (cyc == 1) begin busy1 = busy; done1 = done; end
      if (cyc == 2) busy2 = busy;
      @(posedge clk); #1; start = 1'b0;
    end
    n_checks++;
    if ({saw_cs, saw_v} !== 2'b00) $display("FAIL zero_no_activity got=%b exp=00", {saw_cs, saw_v}); else n_pass++;
    n_checks++;
    if ({busy1, done1, busy2} !== 3'b110) $display("FAIL zero_busy_done got=%b exp=110", {busy1, done1, busy2}); else n_pass++;
    n_checks++;
    if (dones !== 1) $display("FAIL zero_done_count got=%0d exp=1", dones); else n_pass++;

    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), 16'h0100 + 16'(i)});
    start = 1'b1; startAddr = 13'h100; beatCount = 14'd16;
    for (int unsigned cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL ignore_extra_beat got=%h exp=none", m_axis_tdata);
        else begin
          e = exp_q.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== e)
            $display("FAIL ignore_beat got=%h exp=%h", {m_axis_tlast, m_axis_tdata}, e);
          else n_pass++;
        end
        beats++;
      end
      @(posedge clk); #1;
      start = (cyc == 5);
      if (cyc == 5) begin startAddr = 13'h555; beatCount = 14'd3; end
    end
    n_checks++;
    if (beats !== 16) $display("FAIL ignore_beats got=%0d exp=16", beats); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic reached = 1'b0;
    int unsigned beats = 0, dones = 0;
    logic [16:0] e;
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), 16'h0040 + 16'(i)});
    @(posedge clk); #1;
    start = 1'b1; startAddr = 13'h040; beatCount = 14'd16; m_axis_tready = 1'b1;
    for (int unsigned cyc = 0; cyc < 20 && !reached; cyc++) begin
      @(negedge clk);
      if (m_axis_tvalid && beats == 4) begin
        reached = 1'b1;
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, memReadCs, m_axis_tvalid, m_axis_tlast} !== 5'b0 || memReadAddr !== '0 || m_axis_tdata !== '0)
          $display("FAIL mid_reset_outputs got=%b/%h/%h exp=0/0/0",
                   {busy, done, memReadCs, m_axis_tvalid, m_axis_tlast}, memReadAddr, m_axis_tdata);
        else n_pass++;
      end else begin
        if (m_axis_tvalid && m_axis_tready) begin
          n_checks++;
          e = exp_q.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== e)
            $display("FAIL mid_beat got=%h exp=%h", {m_axis_tlast, m_axis_tdata}, e);
          else n_pass++;
          beats++;
        end
        @(posedge clk); #1; start = 1'b0;
      end
    end
    start = 1'b0;
    n_checks++;
    if (!reached) $display("FAIL mid_reset_reached got=0 exp=1"); else n_pass++;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (4) @(posedge clk);

    beats = 0;
    for (int i = 0; i < 2; i++) exp_q.push_back({(i == 1), 16'h0020 + 16'(i)});
    #1 start = 1'b1; startAddr = 13'h020; beatCount = 14'd2;
    for (int unsigned cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (done) dones++;
      if (m_axis_tvalid && m_axis_tready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL post_reset_extra_beat got=%h exp=none", m_axis_tdata);
        else begin
          e = exp_q.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== e)
            $display("FAIL post_reset_beat got=%h exp=%h", {m_axis_tlast, m_axis_tdata}, e);
          else n_pass++;
        end
        beats++;
      end
      @(posedge clk); #1; start = 1'b0;
    end
    n_checks++;
    if (beats !== 2 || dones !== 1) $display("FAIL post_reset_count got=%0d/%0d exp=2/1", beats, dones); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_pixel_swap();
    logic [64:0] exp64[$];
    logic [64:0] e;
    int unsigned beats = 0;
`ifdef BUFFER_STREAM_READER_PIXEL_SWAP_EN
    exp64.push_back({1'b0, 64'h1111_2222_3333_4444});
    exp64.push_back({1'b1, 64'h1112_2223_3334_4445});
`else
    exp64.push_back({1'b0, 64'h4444_3333_2222_1111});
    exp64.push_back({1'b1, 64'h4445_3334_2223_1112});
`endif
    @(posedge clk); #1;
    start64 = 1'b1; startAddr64 = '0; beatCount64 = 12'd2; tready64 = 1'b1;
    for (int unsigned cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (tvalid64 && tready64) begin
        n_checks++;
        if (exp64.size() == 0) $display("FAIL swap_extra_beat got=%h exp=none", tdata64);
        else begin
          e = exp64.pop_front();
          if ({tlast64, tdata64} !== e) $display("FAIL swap_beat got=%h exp=%h", {tlast64, tdata64}, e);
          else n_pass++;
        end
        beats++;
      end
      @(posedge clk); #1; start64 = 1'b0;
    end
    n_checks++;
    if (beats !== 2) $display("FAIL swap_beats got=%0d exp=2", beats); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_and_ignore();
    test_reset_mid();
    test_pixel_swap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/buffer_stream_reader.md
Name: buffer_stream_reader

Overview:
- Memory-to-stream transmitter: reads a contiguous word range from an on-chip buffer RAM and emits it as an AXI-Stream of STREAM_WIDTH beats with tlast.
- Counterpart of the stream-fed texture/buffer writers; used to read back color/depth buffers and replay texture data to a host link.
- Full backpressure support at 1 beat/cycle, despite the RAM's fixed 1-cycle read latency.

Parameters:
- STREAM_WIDTH, 16, stream/RAM word width in bits; multiple of PIXEL_WIDTH (16).
- SIZE, 14, buffer size in bytes as a power of two.
- ADDR_WIDTH, derived, equals SIZE - clog2(STREAM_WIDTH/8); not overridable.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- startAddr  in  ADDR_WIDTH  first word address
- beatCount  in  ADDR_WIDTH+1  number of beats; 0 is legal
- busy  out  1  high from accepted start until done
- done  out  1  single-cycle pulse at end of transfer
- memReadAddr  out  ADDR_WIDTH  RAM read address, registered
- memReadCs  out  1  read enable; RAM returns data on the next cycle
- memReadData  in  STREAM_WIDTH  RAM read data
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  last beat of transfer
- m_axis_tdata  out  STREAM_WIDTH  beat data

Behaviour:
- Reset (async assert, sync deassert internally): state IDLE; busy=0, done=0, memReadCs=0, memReadAddr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0. Assertion mid-transfer abandons the transfer immediately. No partial tlast is emitted.
- FSM states: IDLE, STREAM, FINISH.
  - IDLE -> STREAM on start with beatCount != 0. Latches startAddr and beatCount; busy=1 on the next cycle.
  - IDLE -> FINISH on start with beatCount == 0. No RAM read, no beat.
  - STREAM -> FINISH on the handshake (tvalid & tready) of the beat with tlast=1.
  - FINISH -> IDLE unconditionally. done=1 for exactly this one cycle; busy=0 from the IDLE cycle on.
- start while busy is ignored; the transfer in progress is unaffected.
- Read issue rule: issue a read (memReadCs=1, address increments) when issuedCount < beatCount and (skid occupancy + reads in flight) < 2. Reads in flight is at most 1.
- Address arithmetic: wraps modulo 2^ADDR_WIDTH (e.g. startAddr = last word, 3 beats -> addresses last, 0, 1).
- Buffering: 2-entry skid FIFO captures memReadData one cycle after each issue. m_axis_* is driven from the FIFO head.
- Latency: start accepted in cycle 0 -> first memReadCs in cycle 1 -> m_axis_tvalid high in cycle 2 with word startAddr.
- Throughput: with tready held high, one beat per cycle and no bubbles.
- AXI rules: once tvalid is high, tvalid, tdata and tlast stay stable until the handshake. tvalid never depends combinationally on tready.
- tlast=1 exactly on beat index beatCount-1.
- tready low indefinitely: the FIFO fills to 2 and reads stop. No data is lost or duplicated.
- Maximum beatCount is 2^ADDR_WIDTH: the whole buffer, read once, ending at startAddr-1.

Optional Feature:
- Macro: BUFFER_STREAM_READER_PIXEL_SWAP_EN.
- Defined: the 16-bit pixels within each beat are emitted in reversed order (pixel 0 moves to the MSB slot). Used for hosts that expect the opposite pixel order. The swap is applied at the FIFO output and adds no latency. When STREAM_WIDTH == 16 it has no effect.
- Undefined: tdata equals memReadData bit-for-bit.

Decomposition:
- Shared package holds:
  - PIXEL_WIDTH = 16 and SUB_PIXEL_WIDTH = 4;
  - the FSM state encoding (IDLE/STREAM/FINISH);
  - a function computing ADDR_WIDTH from SIZE and STREAM_WIDTH, shared with the stream writers.
- One sub-module: stream_skid_fifo (2-entry, STREAM_WIDTH+1 wide carrying tdata+tlast, with valid/ready on both sides).

Test Plan:
- startAddr=0x010, beatCount=4, tready=1, RAM word = address -> tdata 0x0010..0x0013 on 4 consecutive cycles; tvalid first seen 2 cycles after start; tlast only on 0x0013; done pulses once.
- Same transfer with tready toggling 1,0,0,1,0,1... -> exactly 4 beats, in order, no duplicates; tdata/tlast stable while tvalid & !tready; at most 2 reads ahead of the consumer.
- SIZE=14, STREAM_WIDTH=16 (ADDR_WIDTH=13), startAddr=0x1FFE, beatCount=4 -> addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- beatCount=0 -> no memReadCs, no tvalid; busy high 1 cycle; done pulses 1 cycle later. A start pulse during a 16-beat transfer is ignored.
- resetn asserted during beat 5 of 16 -> all outputs 0 asynchronously. A new transfer after release (startAddr=0x020, beatCount=2) runs cleanly.
- STREAM_WIDTH=64 with BUFFER_STREAM_READER_PIXEL_SWAP_EN defined, RAM word 0x4444_3333_2222_1111 -> tdata 0x1111_2222_3333_4444. With the macro undefined, tdata is unchanged.
